// File: rtl/inst_fetch_if.sv
// Fetch-side bus between the instruction fetch controller, the instruction ROM and decode.
// master = fetch controller, slave = ROM/decode/control environment.
interface inst_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              inst_valid;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;
    logic [15:0]       fetch_count;

    modport master (
        output rom_addr,
        input  rom_inst,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output halted,
        output fetch_count
    );

    modport slave (
        input  rom_addr,
        output rom_inst,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: walks a fetch PC over a combinational ROM, buffers
// {pc, inst} pairs in a small prefetch FIFO and handles redirects and halt/resume.
module inst_fetch_ctrl #(
    parameter int              ADDR_W   = 8,
    parameter int              INST_W   = 16,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [15:0]       fetch_count_reg;
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic pop;
    logic push;
    logic fifo_full;

    assign fifo_full = (count_reg == CNT_W'(DEPTH));
    assign pop       = (count_reg != '0) && bus.inst_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push      = (state_reg == ST_RUN) && !bus.halt && !bus.redirect_valid
                       && (!fifo_full || pop);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_pc[gi]   <= '0;
                    mem_inst[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_pc[gi]   <= pc_reg;
                    mem_inst[gi] <= bus.rom_inst;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            pc_reg          <= RESET_PC;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            fetch_count_reg <= '0;
        end else if (bus.redirect_valid) begin
            // Flush everything (a same-edge pop is simply discarded with the rest).
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
            pc_reg     <= bus.redirect_pc;
        end else begin
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                pc_reg     <= pc_reg + 1'b1;
                if (fetch_count_reg != 16'hFFFF) begin
                    fetch_count_reg <= fetch_count_reg + 16'd1;
                end
            end
            count_reg <= count_next;

            case (state_reg)
                ST_RUN: begin
                    if (bus.halt) state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!bus.halt) begin
                        state_reg <= ST_RUN;
                    end else if (count_next == '0) begin
                        state_reg <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (!bus.halt) state_reg <= ST_RUN;
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign bus.rom_addr    = pc_reg;
    assign bus.inst_valid  = (count_reg != '0);
    assign bus.inst_data   = mem_inst[rd_ptr_reg];
    assign bus.inst_pc     = mem_pc[rd_ptr_reg];
    assign bus.halted      = (state_reg == ST_HALTED);
    assign bus.fetch_count = fetch_count_reg;
endmodule
